// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: opcodes, funct3 encodings,
// M-stage states and sticky fault codes.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FAULT
  } mstate_t;

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR) ||
           (opc == OPC_LOAD);
  endfunction

  // size is funct3[1:0]: 00 byte, 01 half, 1x word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == 2'b01) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Load data path: picks the addressed byte/half lane from the memory word and
// sign- or zero-extends it according to funct3.
module riscv_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   data = 32'(lane_b);
      F3_LH:   data = 32'(lane_h);
      F3_LBU:  data = {24'h0, lane_b};
      F3_LHU:  data = {16'h0, lane_h};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_mem_stage.sv
// RV32I memory-access stage: data-memory handshake with wait states, store lane
// steering, load alignment, sticky fault handling and the registered MW bundle.
module riscv_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            em_valid,
  input  logic [31:0]     em_instr,
  input  logic [XLEN-1:0] em_addr,
  input  logic [XLEN-1:0] em_rs2,
  input  logic [XLEN-1:0] em_eresult,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            m_stall,
  output logic            mw_valid,
  output logic [4:0]      mw_rd,
  output logic            mw_wb_en,
  output logic [XLEN-1:0] mw_wb_data,
  output logic [1:0]      m_fault
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W:0] MAX_CNT = MAX_WAIT[CNT_W:0];

  mstate_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [1:0]       fault_q, fault_d;
  logic             mw_valid_q, mw_valid_d;
  logic [4:0]       mw_rd_q, mw_rd_d;
  logic             mw_wb_en_q, mw_wb_en_d;
  logic [XLEN-1:0]  mw_wb_data_q, mw_wb_data_d;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       rd;
  logic             is_load, is_store, is_mem, bad_align, timeout;
  logic             req, stall;
  logic [3:0]       st_mask;
  logic [XLEN-1:0]  st_wdata;
  logic [XLEN-1:0]  load_data;
  logic             unused_instr_hi;

  assign opcode          = em_instr[6:0];
  assign rd              = em_instr[11:7];
  assign funct3          = em_instr[14:12];
  assign unused_instr_hi = ^em_instr[31:15];

  assign is_load   = em_valid && (opcode == OPC_LOAD);
  assign is_store  = em_valid && (opcode == OPC_STORE);
  assign is_mem    = is_load || is_store;
  assign bad_align = is_mem && misaligned(funct3[1:0], em_addr[1:0]);
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign timeout   = (MAX_WAIT > 0) && (cnt_inc == MAX_CNT);

  riscv_load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (em_addr[1:0]),
    .funct3  (funct3),
    .data    (load_data)
  );

  always_comb begin
    case (funct3)
      F3_SB: begin
        st_mask  = 4'b0001 << em_addr[1:0];
        st_wdata = {4{em_rs2[7:0]}};
      end
      F3_SH: begin
        st_mask  = em_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{em_rs2[15:0]}};
      end
      F3_SW: begin
        st_mask  = 4'b1111;
        st_wdata = em_rs2;
      end
      default: begin
        st_mask  = 4'b1111;
        st_wdata = em_rs2;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fault_d      = fault_q;
    mw_valid_d   = 1'b0;
    mw_rd_d      = '0;
    mw_wb_en_d   = 1'b0;
    mw_wb_data_d = '0;
    req          = 1'b0;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bad_align) begin
          stall      = 1'b1;
          mw_valid_d = 1'b1;
          mw_rd_d    = rd;
          fault_d    = FAULT_MISALIGN;
          state_d    = FAULT;
        end else if (is_mem) begin
          req = 1'b1;
        end else begin
          mw_valid_d = em_valid;
          if (em_valid) begin
            mw_rd_d      = rd;
            mw_wb_en_d   = writes_rd(opcode) && (rd != 5'd0);
            mw_wb_data_d = em_eresult;
          end
        end
      end
      WAIT:    req   = 1'b1;
      FAULT:   stall = 1'b1;
      default: state_d = IDLE;
    endcase

    // Shared completion / wait / timeout handling for an outstanding request
    if (req) begin
      if (mem_ready) begin
        mw_valid_d   = 1'b1;
        mw_rd_d      = rd;
        mw_wb_en_d   = is_load && (rd != 5'd0);
        mw_wb_data_d = is_load ? load_data : '0;
        cnt_d        = '0;
        state_d      = IDLE;
      end else if (timeout) begin
        stall      = 1'b1;
        mw_valid_d = 1'b1;
        mw_rd_d    = rd;
        fault_d    = FAULT_TIMEOUT;
        cnt_d      = '0;
        state_d    = FAULT;
      end else begin
        stall   = 1'b1;
        cnt_d   = cnt_inc[CNT_W-1:0];
        state_d = WAIT;
      end
    end

    if (reset) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  // MW pipeline register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fault_q      <= FAULT_NONE;
      mw_valid_q   <= 1'b0;
      mw_rd_q      <= '0;
      mw_wb_en_q   <= 1'b0;
      mw_wb_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      mw_valid_q   <= mw_valid_d;
      mw_rd_q      <= mw_rd_d;
      mw_wb_en_q   <= mw_wb_en_d;
      mw_wb_data_q <= mw_wb_data_d;
    end
  end

  assign mem_req    = req;
  assign mem_we     = req && is_store;
  assign mem_addr   = {em_addr[XLEN-1:2], 2'b00};
  assign mem_wdata  = st_wdata;
  assign mem_wmask  = is_store ? st_mask : 4'b0000;
  assign m_stall    = stall;
  assign mw_valid   = mw_valid_q;
  assign mw_rd      = mw_rd_q;
  assign mw_wb_en   = mw_wb_en_q;
  assign mw_wb_data = mw_wb_data_q;
  assign m_fault    = fault_q;

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Bench for riscv_mem_stage: directed vector table, hand-written reset/fault
// sequences and randomized ops checked against an arithmetic reference model.
module tb_riscv_mem_stage;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] BR  = 7'b1100011;

  logic        clk, reset;
  logic        em_valid;
  logic [31:0] em_instr, em_addr, em_rs2, em_eresult;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        m_stall, mw_valid, mw_wb_en;
  logic [4:0]  mw_rd;
  logic [31:0] mw_wb_data;
  logic [1:0]  m_fault;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_mem_stage #(.XLEN(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .em_valid(em_valid), .em_instr(em_instr), .em_addr(em_addr),
    .em_rs2(em_rs2), .em_eresult(em_eresult),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .m_stall(m_stall), .mw_valid(mw_valid), .mw_rd(mw_rd),
    .mw_wb_en(mw_wb_en), .mw_wb_data(mw_wb_data), .m_fault(m_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (now=%0t, required finish)", $time);
    $fatal(1);
  end

  typedef struct {
    logic        v;
    logic [31:0] instr, addr, rs2, eres, rdata;
    int          waits;
    logic        e_req, e_we;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic        e_valid, e_wb_en;
    logic [4:0]  e_rd;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, opc};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [31:0] instr, addr, rs2, eres, rdata,
                               input int waits, input logic e_req, e_we, input logic [3:0] e_mask,
                               input logic [31:0] e_wdata, input logic e_valid, e_wb_en,
                               input logic [4:0] e_rd, input logic chk_data, input logic [31:0] e_data);
    vec_t r;
    r.v = v; r.instr = instr; r.addr = addr; r.rs2 = rs2; r.eres = eres; r.rdata = rdata;
    r.waits = waits; r.e_req = e_req; r.e_we = e_we; r.e_mask = e_mask; r.e_wdata = e_wdata;
    r.e_valid = e_valid; r.e_wb_en = e_wb_en; r.e_rd = e_rd; r.chk_data = chk_data; r.e_data = e_data;
    return r;
  endfunction

  // Reference model: lane extraction and extension by plain arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word);
    logic [31:0] sh;
    int          val;
    sh = word >> (8 * a);
    case (f3)
      3'b000: begin val = int'(sh & 32'hFF);   if (val > 127)   val -= 256;   return 32'(val); end
      3'b001: begin val = int'(sh & 32'hFFFF); if (val > 32767) val -= 65536; return 32'(val); end
      3'b100: return sh & 32'hFF;
      3'b101: return sh & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'(1 << a);
      2'b01:   return 4'(3 << a);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'b00:   return (rs2 & 32'hFF) * 32'h0101_0101;
      2'b01:   return (rs2 & 32'hFFFF) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  // Drive one EM op, hold it through v.waits not-ready cycles, then complete
  task automatic apply(input vec_t v, input string tag);
    em_valid = v.v; em_instr = v.instr; em_addr = v.addr; em_rs2 = v.rs2; em_eresult = v.eres;
    for (int k = 0; k <= v.waits; k++) begin
      mem_ready = (k == v.waits);
      mem_rdata = (k == v.waits) ? v.rdata : (32'h5A5A_0F0F ^ 32'(k));
      @(negedge clk);
      chk({tag, "_req"}, mem_req, v.e_req);
      chk({tag, "_stall"}, m_stall, (k < v.waits));
      if (v.e_req) begin
        chk({tag, "_we"}, mem_we, v.e_we);
        chk({tag, "_addr"}, mem_addr, {v.addr[31:2], 2'b00});
        chk({tag, "_mask"}, mem_wmask, v.e_mask);
        if (v.e_we) chk({tag, "_wdata"}, mem_wdata, v.e_wdata);
      end
      @(posedge clk); #1;
      if (k < v.waits) chk({tag, "_bubble"}, mw_valid, 1'b0);
    end
    chk({tag, "_mw_valid"}, mw_valid, v.e_valid);
    chk({tag, "_wb_en"}, mw_wb_en, v.e_wb_en);
    if (v.e_valid) chk({tag, "_rd"}, mw_rd, v.e_rd);
    if (v.chk_data) chk({tag, "_wb_data"}, mw_wb_data, v.e_data);
    em_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; em_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  vec_t tbl [14];

  initial begin
    reset = 1'b1; em_valid = 1'b1; em_instr = ins(LD, 3'b010, 5'd3); em_addr = 32'h10;
    em_rs2 = '0; em_eresult = '0; mem_ready = 1'b0; mem_rdata = '0;

    tbl[0]  = mkv(1, ins(OP, 0, 5), 0, 0, 32'h1234, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 5, 1, 32'h1234);
    tbl[1]  = mkv(1, ins(ST, 0, 3), 32'h103, 32'hAABBCCDD, 0, 0, 0, 1, 1, 4'b1000, 32'hDDDDDDDD, 1, 0, 3, 0, 0);
    tbl[2]  = mkv(1, ins(LD, 0, 7), 32'h202, 0, 0, 32'h00800000, 3, 1, 0, 4'b0000, 0, 1, 1, 7, 1, 32'hFFFFFF80);
    tbl[3]  = mkv(1, ins(LD, 5, 9), 32'h2, 0, 0, 32'h80010000, 0, 1, 0, 4'b0000, 0, 1, 1, 9, 1, 32'h00008001);
    tbl[4]  = mkv(1, ins(ST, 1, 0), 32'h102, 32'h12345678, 0, 0, 1, 1, 1, 4'b1100, 32'h56785678, 1, 0, 0, 0, 0);
    tbl[5]  = mkv(1, ins(ST, 2, 0), 32'h40, 32'hCAFEF00D, 0, 0, 2, 1, 1, 4'b1111, 32'hCAFEF00D, 1, 0, 0, 0, 0);
    tbl[6]  = mkv(1, ins(LD, 2, 31), 32'h10, 0, 0, 32'hDEADBEEF, 0, 1, 0, 4'b0000, 0, 1, 1, 31, 1, 32'hDEADBEEF);
    tbl[7]  = mkv(1, ins(LD, 1, 12), 32'h0, 0, 0, 32'h1234F00D, 1, 1, 0, 4'b0000, 0, 1, 1, 12, 1, 32'hFFFFF00D);
    tbl[8]  = mkv(1, ins(LD, 4, 2), 32'h1, 0, 0, 32'h0000AB00, 2, 1, 0, 4'b0000, 0, 1, 1, 2, 1, 32'h000000AB);
    tbl[9]  = mkv(1, ins(LD, 2, 0), 32'h20, 0, 0, 32'h11223344, 0, 1, 0, 4'b0000, 0, 1, 0, 0, 1, 32'h11223344);
    tbl[10] = mkv(0, ins(LD, 2, 4), 32'h20, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[11] = mkv(1, ins(BR, 0, 6), 0, 0, 32'h55, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 6, 1, 32'h55);
    tbl[12] = mkv(1, ins(LD, 0, 8), 32'h3, 0, 0, 32'h7F000000, 0, 1, 0, 4'b0000, 0, 1, 1, 8, 1, 32'h7F);
    tbl[13] = mkv(1, ins(ST, 0, 0), 32'h1, 32'h000000A5, 0, 0, 3, 1, 1, 4'b0010, 32'hA5A5A5A5, 1, 0, 0, 0, 0);

    // Reset with a load presented: no request, no stall, cleared MW bundle
    @(negedge clk);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_stall", m_stall, 1'b0);
    @(posedge clk); #1;
    chk("rst_mw_valid", mw_valid, 1'b0);
    chk("rst_wb_en", mw_wb_en, 1'b0);
    chk("rst_rd", mw_rd, 5'd0);
    chk("rst_wb_data", mw_wb_data, 32'h0);
    chk("rst_fault", m_fault, 2'b00);
    reset = 1'b0; em_valid = 1'b0;

    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset while a load is waiting
    em_valid = 1'b1; em_instr = ins(LD, 3'b010, 5'd4); em_addr = 32'h30; mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstw_pend_req", mem_req, 1'b1);
      chk("rstw_pend_stall", m_stall, 1'b1);
      @(posedge clk); #1;
      chk("rstw_pend_bubble", mw_valid, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_req", mem_req, 1'b0);
    chk("rstw_stall", m_stall, 1'b0);
    @(posedge clk); #1;
    chk("rstw_mw_valid", mw_valid, 1'b0);
    chk("rstw_wb_en", mw_wb_en, 1'b0);
    chk("rstw_rd", mw_rd, 5'd0);
    chk("rstw_wb_data", mw_wb_data, 32'h0);
    reset = 1'b0; em_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_ready_req", mem_req, 1'b0);
    @(posedge clk); #1;
    chk("late_ready_mw_valid", mw_valid, 1'b0);
    mem_ready = 1'b0;
    apply(tbl[2], "rstw_lb3");

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      vec_t        r;
      int          kind, sel;
      logic [2:0]  f3;
      logic [4:0]  rdr;
      logic [6:0]  opc;
      logic [31:0] base, a, rs2v, word, eres;
      kind = int'($urandom_range(0, 9));
      sel  = int'($urandom_range(0, 4));
      rdr  = 5'($urandom_range(0, 31));
      base = $urandom & 32'hFFFF_FFF0;
      rs2v = $urandom;
      word = $urandom;
      eres = $urandom;
      if (kind == 0) begin
        r = mkv(0, ins(LD, 3'b010, rdr), base, rs2v, eres, word, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
      end else if (kind <= 3) begin
        opc = (sel == 0) ? OP : (sel == 1) ? OPI : (sel == 2) ? LUI : BR;
        r = mkv(1, ins(opc, 3'($urandom_range(0, 7)), rdr), base, rs2v, eres, word, 0, 0, 0, 4'b0000, 0,
                1, (opc != BR) && (rdr != 0), rdr, 1, eres);
      end else if (kind <= 6) begin
        f3 = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b001 : (sel == 2) ? 3'b010 : (sel == 3) ? 3'b100 : 3'b101;
        a = base + ((f3[1:0] == 2'b00) ? $urandom_range(0, 3) : (f3[1:0] == 2'b01) ? 2 * $urandom_range(0, 1) : 0);
        r = mkv(1, ins(LD, f3, rdr), a, rs2v, eres, word, int'($urandom_range(0, 3)), 1, 0, 4'b0000, 0,
                1, rdr != 0, rdr, 1, ref_load(f3, a[1:0], word));
      end else begin
        f3 = 3'(sel % 3);
        a = base + ((f3 == 3'b000) ? $urandom_range(0, 3) : (f3 == 3'b001) ? 2 * $urandom_range(0, 1) : 0);
        r = mkv(1, ins(ST, f3, rdr), a, rs2v, eres, word, int'($urandom_range(0, 3)), 1, 1,
                ref_mask(f3, a[1:0]), ref_wdata(f3, rs2v), 1, 0, rdr, 0, 0);
      end
      apply(r, $sformatf("rnd%0d", i));
    end
    chk("rnd_fault_none", m_fault, 2'b00);

    // Misaligned LW: never requests, retires without write-back, sticky fault
    em_valid = 1'b1; em_instr = ins(LD, 3'b010, 5'd5); em_addr = 32'h6; mem_ready = 1'b1;
    @(negedge clk);
    chk("mis_req", mem_req, 1'b0);
    chk("mis_stall", m_stall, 1'b1);
    @(posedge clk); #1;
    chk("mis_mw_valid", mw_valid, 1'b1);
    chk("mis_wb_en", mw_wb_en, 1'b0);
    chk("mis_fault", m_fault, 2'b01);
    em_instr = ins(OP, 3'b000, 5'd9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("misf_req", mem_req, 1'b0);
      chk("misf_stall", m_stall, 1'b1);
      @(posedge clk); #1;
      chk("misf_mw_valid", mw_valid, 1'b0);
      chk("misf_fault", m_fault, 2'b01);
    end
    do_reset();
    chk("mis_rst_fault", m_fault, 2'b00);

    // Timeout: four not-ready cycles with MAX_WAIT=4
    em_valid = 1'b1; em_instr = ins(LD, 3'b010, 5'd6); em_addr = 32'h44; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_req", mem_req, 1'b1);
      chk("to_stall", m_stall, 1'b1);
      @(posedge clk); #1;
      if (k < 3) begin
        chk("to_wait_mw_valid", mw_valid, 1'b0);
        chk("to_wait_fault", m_fault, 2'b00);
      end else begin
        chk("to_fault", m_fault, 2'b10);
        chk("to_mw_valid", mw_valid, 1'b1);
        chk("to_wb_en", mw_wb_en, 1'b0);
      end
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("tof_req", mem_req, 1'b0);
      chk("tof_stall", m_stall, 1'b1);
      @(posedge clk); #1;
      chk("tof_mw_valid", mw_valid, 1'b0);
      chk("tof_fault", m_fault, 2'b10);
    end
    do_reset();
    chk("to_rst_fault", m_fault, 2'b00);
    apply(tbl[0], "post_alu");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
